// File: rtl/stdp_pkg.sv
// Shared types and helpers for the STDP weight read-modify-write controller.
// Stage fields are sized by the package widths; keep top-level widths in step with them.
package stdp_pkg;

  localparam int STDP_ADDR_BITS  = 4;
  localparam int STDP_DELTA_BITS = 8;

  typedef enum logic {
    OP_INF = 1'b0,
    OP_UPD = 1'b1
  } op_e;

  typedef struct packed {
    logic                              valid;
    op_e                               op;
    logic [STDP_ADDR_BITS-1:0]         addr;
    logic signed [STDP_DELTA_BITS-1:0] delta;
  } stage_t;

  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] x,
    input logic signed [63:0] lo,
    input logic signed [63:0] hi
  );
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/stdp_weight_rmw_ctrl_sat_add.sv
// Widening signed add of weight and STDP delta, clamped to [W_MIN, W_MAX].
module stdp_sat_add
  import stdp_pkg::*;
#(
  parameter int DATA_WIDTH  = 18,
  parameter int DELTA_WIDTH = 8,
  parameter logic signed [DATA_WIDTH-1:0] W_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}},
  parameter logic signed [DATA_WIDTH-1:0] W_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}}
) (
  input  logic signed [DATA_WIDTH-1:0]  operand,
  input  logic signed [DELTA_WIDTH-1:0] delta,
  output logic signed [DATA_WIDTH-1:0]  result,
  output logic                          sat
);

  logic signed [DATA_WIDTH:0] sum;
  logic signed [63:0]         wide;

  always_comb begin
    // One extra bit is enough: |delta| never exceeds the weight range.
    sum    = (DATA_WIDTH+1)'(operand) + (DATA_WIDTH+1)'(delta);
    wide   = 64'(sum);
    result = DATA_WIDTH'(saturate(wide, 64'(W_MIN), 64'(W_MAX)));
    sat    = (wide > 64'(W_MAX)) || (wide < 64'(W_MIN));
  end

endmodule

// File: rtl/stdp_weight_rmw_ctrl.sv
// Arbiter and 3-stage read-modify-write pipeline sharing one weight RAM read port
// between inference fetches and STDP updates, with write forwarding for coherence.
module stdp_weight_rmw_ctrl
  import stdp_pkg::*;
#(
  parameter int DATA_WIDTH   = 18,
  parameter int ADDR_WIDTH   = STDP_ADDR_BITS,
  parameter int DELTA_WIDTH  = STDP_DELTA_BITS,
  parameter logic signed [DATA_WIDTH-1:0] W_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}},
  parameter logic signed [DATA_WIDTH-1:0] W_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}},
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          inf_req,
  input  logic [ADDR_WIDTH-1:0]         inf_addr,
  output logic                          inf_ready,
  output logic                          inf_valid,
  output logic signed [DATA_WIDTH-1:0]  inf_data,
  input  logic                          upd_valid,
  input  logic [ADDR_WIDTH-1:0]         upd_addr,
  input  logic signed [DELTA_WIDTH-1:0] upd_delta,
  output logic                          upd_ready,
  output logic [ADDR_WIDTH-1:0]         ram_raddr,
  input  logic signed [DATA_WIDTH-1:0]  ram_rdata,
  output logic [ADDR_WIDTH-1:0]         ram_waddr,
  output logic signed [DATA_WIDTH-1:0]  ram_wdata,
  output logic                          ram_we,
  output logic [15:0]                   sat_count,
  output logic [15:0]                   upd_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0]                 starve_reg;
  logic [ADDR_WIDTH-1:0]         raddr_reg;
  stage_t                        r_reg;
  logic                          we_reg;
  logic [ADDR_WIDTH-1:0]         waddr_reg;
  logic signed [DATA_WIDTH-1:0]  wdata_reg;
  logic                          ret_valid_reg;
  logic [ADDR_WIDTH-1:0]         ret_addr_reg;
  logic signed [DATA_WIDTH-1:0]  ret_data_reg;
  logic [15:0]                   sat_cnt_reg;
  logic [15:0]                   upd_cnt_reg;

  logic                          force_upd, grant_upd, grant_inf;
  stage_t                        issue;
  logic [ADDR_WIDTH-1:0]         r_addr;
  logic signed [DELTA_WIDTH-1:0] r_delta;
  logic                          r_upd;
  logic signed [DATA_WIDTH-1:0]  operand, sum;
  logic                          sum_sat;

  // Inference wins unless the update has been starved for STARVE_LIMIT cycles.
  assign force_upd = upd_valid && (starve_reg == STARVE_MAX);
  assign grant_upd = !rst && upd_valid && (!inf_req || force_upd);
  assign grant_inf = !rst && inf_req && !grant_upd;

  assign inf_ready = grant_inf;
  assign upd_ready = grant_upd;

  always_comb begin
    issue     = '0;
    ram_raddr = raddr_reg;
    if (grant_upd) begin
      issue.valid = 1'b1;
      issue.op    = OP_UPD;
      issue.addr  = STDP_ADDR_BITS'(upd_addr);
      issue.delta = STDP_DELTA_BITS'(upd_delta);
      ram_raddr   = upd_addr;
    end else if (grant_inf) begin
      issue.valid = 1'b1;
      issue.op    = OP_INF;
      issue.addr  = STDP_ADDR_BITS'(inf_addr);
      ram_raddr   = inf_addr;
    end
  end

  assign r_addr  = ADDR_WIDTH'(r_reg.addr);
  assign r_delta = DELTA_WIDTH'(r_reg.delta);
  assign r_upd   = r_reg.valid && (r_reg.op == OP_UPD);

  // The RAM returns pre-write data for writes landing at or just before the read edge.
  always_comb begin
    operand = ram_rdata;
    if (ret_valid_reg && (ret_addr_reg == r_addr)) operand = ret_data_reg;
    if (we_reg && (waddr_reg == r_addr))           operand = wdata_reg;
  end

  stdp_sat_add #(
    .DATA_WIDTH (DATA_WIDTH),
    .DELTA_WIDTH(DELTA_WIDTH),
    .W_MAX      (W_MAX),
    .W_MIN      (W_MIN)
  ) u_sat_add (
    .operand(operand),
    .delta  (r_delta),
    .result (sum),
    .sat    (sum_sat)
  );

  assign inf_valid = r_reg.valid && (r_reg.op == OP_INF);
  assign inf_data  = inf_valid ? operand : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_reg    <= '0;
      raddr_reg     <= '0;
      r_reg         <= '0;
      we_reg        <= 1'b0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      ret_valid_reg <= 1'b0;
      ret_addr_reg  <= '0;
      ret_data_reg  <= '0;
      sat_cnt_reg   <= '0;
      upd_cnt_reg   <= '0;
    end else begin
      if (grant_upd)      starve_reg <= '0;
      else if (upd_valid) starve_reg <= starve_reg + 1'b1;
      if (issue.valid) raddr_reg <= ram_raddr;
      r_reg  <= issue;
      we_reg <= r_upd;
      if (r_upd) begin
        waddr_reg <= r_addr;
        wdata_reg <= sum;
      end
      if (r_upd && sum_sat && (sat_cnt_reg != 16'hFFFF)) sat_cnt_reg <= sat_cnt_reg + 16'd1;
      ret_valid_reg <= we_reg;
      ret_addr_reg  <= waddr_reg;
      ret_data_reg  <= wdata_reg;
      if (we_reg) upd_cnt_reg <= upd_cnt_reg + 16'd1;
    end
  end

  assign ram_we    = we_reg;
  assign ram_waddr = waddr_reg;
  assign ram_wdata = wdata_reg;
  assign sat_count = sat_cnt_reg;
  assign upd_count = upd_cnt_reg;

endmodule

// File: tb/tb_stdp_weight_rmw_ctrl.sv
// Bench for stdp_weight_rmw_ctrl: RAM model, sequential-semantics weight model
// checked every cycle, directed literal cases and a randomized traffic phase.
module tb_stdp_weight_rmw_ctrl;

  localparam int DW   = 18;
  localparam int AW   = 4;
  localparam int DLW  = 8;
  localparam int WMAX = 131071;
  localparam int WMIN = -131072;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  inf_req = 1'b0;
  logic [AW-1:0]         inf_addr = '0;
  logic                  inf_ready, inf_valid;
  logic signed [DW-1:0]  inf_data;
  logic                  upd_valid = 1'b0;
  logic [AW-1:0]         upd_addr = '0;
  logic signed [DLW-1:0] upd_delta = '0;
  logic                  upd_ready;
  logic [AW-1:0]         ram_raddr, ram_waddr;
  logic signed [DW-1:0]  ram_rdata = '0;
  logic signed [DW-1:0]  ram_wdata;
  logic                  ram_we;
  logic [15:0]           sat_count, upd_count;

  logic                  poke_req = 1'b0;
  logic [AW-1:0]         poke_addr = '0;
  logic signed [DW-1:0]  poke_val = '0;
  logic signed [DW-1:0]  mem [16] = '{default: '0};

  always #5 clk = ~clk;

  stdp_weight_rmw_ctrl dut (
    .clk(clk), .rst(rst),
    .inf_req(inf_req), .inf_addr(inf_addr), .inf_ready(inf_ready),
    .inf_valid(inf_valid), .inf_data(inf_data),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_delta(upd_delta), .upd_ready(upd_ready),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .sat_count(sat_count), .upd_count(upd_count)
  );

  // Registered-read RAM returning old data on a same-edge write.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_raddr];
    if (ram_we)   mem[ram_waddr] <= ram_wdata;
    if (poke_req) mem[poke_addr] <= poke_val;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: golden = weights as if every accepted update applied instantly;
  // committed = weights actually written so far. Slots hold per-cycle expectations.
  int golden [16]    = '{default: 0};
  int committed [16] = '{default: 0};
  bit ei_v [8];
  int ei_d [8];
  bit ew_v [8];
  int ew_a [8];
  int ew_d [8];
  bit eu_inc [8];
  bit es_inc [8];
  int exp_upd_cnt = 0, exp_sat_cnt = 0, starve = 0, last_raddr = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clear_slot(input int s);
    ei_v[s] = 0; ei_d[s] = 0; ew_v[s] = 0; ew_a[s] = 0; ew_d[s] = 0;
    eu_inc[s] = 0; es_inc[s] = 0;
  endtask

  task automatic model_cycle();
    int s, a, sum;
    bit sat, fu, eu, ei;
    s = cyc % 8;
    chk("inf_valid", inf_valid, ei_v[s]);
    if (ei_v[s]) chk("inf_data", inf_data, ei_d[s]);
    chk("ram_we", ram_we, ew_v[s]);
    if (ew_v[s]) begin
      chk("ram_waddr", ram_waddr, ew_a[s]);
      chk("ram_wdata", ram_wdata, ew_d[s]);
      committed[ew_a[s]] = ew_d[s];
    end
    if (eu_inc[s]) exp_upd_cnt = (exp_upd_cnt + 1) % 65536;
    if (es_inc[s] && exp_sat_cnt < 65535) exp_sat_cnt++;
    chk("upd_count", upd_count, exp_upd_cnt);
    chk("sat_count", sat_count, exp_sat_cnt);
    clear_slot(s);
    if (rst) begin
      chk("upd_ready_rst", upd_ready, 0);
      chk("inf_ready_rst", inf_ready, 0);
      chk("ram_raddr", ram_raddr, last_raddr);
      for (int k = 0; k < 8; k++) clear_slot(k);
      starve = 0; exp_upd_cnt = 0; exp_sat_cnt = 0; last_raddr = 0;
      for (int k = 0; k < 16; k++) golden[k] = committed[k];
    end else begin
      if (poke_req) begin
        golden[poke_addr] = poke_val;
        committed[poke_addr] = poke_val;
      end
      fu = upd_valid && (starve == 4);
      eu = upd_valid && (!inf_req || fu);
      ei = inf_req && !eu;
      chk("upd_ready", upd_ready, eu);
      chk("inf_ready", inf_ready, ei);
      if (eu) begin
        a = upd_addr;
        sum = golden[a] + int'(upd_delta);
        sat = 0;
        if (sum > WMAX) begin sum = WMAX; sat = 1; end
        else if (sum < WMIN) begin sum = WMIN; sat = 1; end
        golden[a] = sum;
        ew_v[(cyc+2)%8] = 1; ew_a[(cyc+2)%8] = a; ew_d[(cyc+2)%8] = sum;
        if (sat) es_inc[(cyc+2)%8] = 1;
        eu_inc[(cyc+3)%8] = 1;
        starve = 0;
        last_raddr = a;
        $display("cyc %0d UPD addr %0d delta %0d -> %0d", cyc, a, int'(upd_delta), sum);
      end else if (upd_valid) begin
        starve++;
      end
      if (ei) begin
        ei_v[(cyc+1)%8] = 1;
        ei_d[(cyc+1)%8] = golden[inf_addr];
        last_raddr = inf_addr;
        $display("cyc %0d INF addr %0d -> %0d", cyc, inf_addr, golden[inf_addr]);
      end
      chk("ram_raddr", ram_raddr, last_raddr);
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inf_req = 1'b0;
    upd_valid = 1'b0;
  endtask

  task automatic upd(input int a, input int d);
    upd_valid = 1'b1;
    upd_addr  = AW'(a);
    upd_delta = DLW'(d);
  endtask

  task automatic poke(input int a, input int v);
    idle();
    poke_req = 1'b1; poke_addr = AW'(a); poke_val = DW'(v);
    step();
    poke_req = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    step(); step();
    chk("lit_rst_inf_ready", inf_ready, 0);
    chk("lit_rst_upd_ready", upd_ready, 0);
    chk("lit_rst_inf_valid", inf_valid, 0);
    chk("lit_rst_inf_data", inf_data, 0);
    chk("lit_rst_ram_we", ram_we, 0);
    chk("lit_rst_ram_raddr", ram_raddr, 0);
    chk("lit_rst_ram_waddr", ram_waddr, 0);
    chk("lit_rst_ram_wdata", ram_wdata, 0);
    chk("lit_rst_upd_count", upd_count, 0);
    chk("lit_rst_sat_count", sat_count, 0);
    rst = 1'b0;

    // Single update
    poke(3, 100);
    upd(3, 5); step();
    idle(); step();
    chk("lit_single_we", ram_we, 1);
    chk("lit_single_waddr", ram_waddr, 3);
    chk("lit_single_wdata", ram_wdata, 105);
    step();
    chk("lit_single_upd_count", upd_count, 1);

    // Back-to-back same address
    poke(7, 0);
    upd(7, 1); step();
    upd(7, 2); step();
    chk("lit_b2b_wdata0", ram_wdata, 1);
    upd(7, 3); step();
    chk("lit_b2b_wdata1", ram_wdata, 3);
    idle(); step();
    chk("lit_b2b_wdata2", ram_wdata, 6);
    step(); step();

    // Gap forwarding via the retired register
    poke(2, 10); poke(5, 0);
    upd(2, 4); step();
    upd(5, 1); step();
    upd(2, 4); step();
    idle(); step();
    chk("lit_gap_waddr", ram_waddr, 2);
    chk("lit_gap_wdata", ram_wdata, 18);
    step(); step();

    // Saturation at both bounds
    do_reset();
    poke(1, 131070); poke(9, -131072);
    upd(1, 5); step();
    upd(9, -1); step();
    chk("lit_sat_hi_wdata", ram_wdata, 131071);
    chk("lit_sat_count1", sat_count, 1);
    idle(); step();
    chk("lit_sat_lo_wdata", ram_wdata, -131072);
    chk("lit_sat_count2", sat_count, 2);
    step(); step();

    // Starvation arbitration, then inference right behind the update
    do_reset();
    poke(4, 50);
    inf_req = 1'b1; inf_addr = 4'd4;
    upd(4, 3);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("lit_starve_upd_ready", upd_ready, (i == 4));
      chk("lit_starve_inf_ready", inf_ready, (i != 4));
      step();
    end
    upd_valid = 1'b0;
    step();
    chk("lit_fwd_inf_valid", inf_valid, 1);
    chk("lit_fwd_inf_data", inf_data, 53);
    idle(); step(); step(); step();

    // Reset mid-update
    do_reset();
    upd(6, 1); step();
    idle(); rst = 1'b1; step();
    chk("lit_midrst_we", ram_we, 0);
    rst = 1'b0; step();
    chk("lit_midrst_we2", ram_we, 0);
    chk("lit_midrst_waddr", ram_waddr, 0);
    chk("lit_midrst_wdata", ram_wdata, 0);
    chk("lit_midrst_upd_count", upd_count, 0);
    chk("lit_midrst_inf_valid", inf_valid, 0);

    // Randomized traffic on a few hot addresses, some near the bounds
    do_reset();
    poke(0, 131000); poke(1, -131000); poke(2, 0); poke(3, 131071);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      inf_req   = ($urandom_range(0, 2) != 0);
      inf_addr  = AW'($urandom_range(0, 3));
      upd_valid = $urandom_range(0, 1) == 1;
      upd_addr  = AW'($urandom_range(0, 3));
      upd_delta = DLW'($urandom_range(0, 255));
      step();
    end
    idle();
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stdp_weight_rmw_ctrl.md
# stdp_weight_rmw_ctrl

Read-modify-write sequencer and arbiter for the synaptic weight dual-port RAM (one read port, one write port, 1-cycle registered read latency). Shares the RAM read port between inference weight fetches and STDP weight updates. Each update reads a weight, adds a signed STDP delta with saturation, and writes it back. Forwarding hides the RAM's read-old-data behaviour, so back-to-back accesses to one address stay coherent.

## Interface
- DATA_WIDTH, 18, signed weight width
- ADDR_WIDTH, 4, weight address width
- DELTA_WIDTH, 8, signed STDP delta width, must be ≤ DATA_WIDTH
- W_MAX, 2**(DATA_WIDTH-1)-1, saturation upper bound
- W_MIN, -2**(DATA_WIDTH-1), saturation lower bound
- STARVE_LIMIT, 4, consecutive update-denied cycles before updates get forced priority

Reset is `rst`: synchronous, active-high. Clock is `clk`.

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inf_req  in  1  inference read request
- inf_addr  in  ADDR_WIDTH  inference read address
- inf_ready  out  1  inference request accepted this cycle
- inf_valid  out  1  inference data valid
- inf_data  out  DATA_WIDTH signed  coherent weight for inference
- upd_valid  in  1  update request
- upd_addr  in  ADDR_WIDTH  update address
- upd_delta  in  DELTA_WIDTH signed  STDP delta
- upd_ready  out  1  update accepted this cycle
- ram_raddr  out  ADDR_WIDTH  RAM read address (combinational from grant)
- ram_rdata  in  DATA_WIDTH signed  RAM read data
- ram_waddr  out  ADDR_WIDTH  RAM write address (registered)
- ram_wdata  out  DATA_WIDTH signed  RAM write data (registered)
- ram_we  out  1  RAM write enable (registered)
- sat_count  out  16  saturated update count, holds at 0xFFFF
- upd_count  out  16  retired update count, wraps

## Operation
- Three pipeline stages:
  - Issue (I): the arbiter grants one requester. ram_raddr = granted address. Op tag {INF, UPD}, address and delta are registered.
  - Return (R): ram_rdata arrives. The operand is chosen by forwarding. INF drives inf_data. UPD computes the saturated sum.
  - Write (W): ram_we/ram_waddr/ram_wdata are registered from R for UPD.
- Arbitration:
  - Inference has priority by default.
  - starve_cnt increments each cycle upd_valid=1 and upd_ready=0, and clears on update grant.
  - When starve_cnt == STARVE_LIMIT, the update is granted and inf_ready=0 for that cycle.
  - No request: ram_raddr holds its last value; the I-stage bubble is invalid.
- Forwarding for the R operand, highest priority first:
  1. W stage valid with same address → W wdata (write occurring this edge, missed by the read).
  2. Retired register (last write, one cycle after W) valid with same address → its data (written at the same edge the read sampled).
  3. Otherwise ram_rdata.
- Arithmetic:
  - sum = operand + sign-extended delta, computed at DATA_WIDTH+1 bits.
  - Clamp to [W_MIN, W_MAX].
  - Clamp event increments sat_count.
  - W-stage retire increments upd_count.
- No backpressure on the inference output; inf_valid is a 1-cycle pulse.

## Timing
- Inference: request granted at cycle t → inf_valid/inf_data at t+1.
- Update: accepted at t → ram_we=1 at t+2; memory holds the new value after the t+2 edge; retired register valid at t+3.
- Throughput: one grant per cycle.
- Back-to-back same-address updates at t, t+1, t+2 accumulate correctly via forwarding.
- Simultaneous inf and upd requests: exactly one ready is high. Both readys are never high together.
- Reset values:
  - inf_ready=0, upd_ready=0, inf_valid=0, ram_we=0.
  - ram_raddr, ram_waddr, ram_wdata, inf_data = 0.
  - Counters and starve_cnt = 0.
  - All stage valid bits = 0.
- Reset mid-operation discards in-flight updates. No write is issued in the cycle after reset deasserts.
- Readys are low while rst=1.

## Structure
- Shared package `stdp_pkg`:
  - op_e enum {OP_INF, OP_UPD}.
  - Stage struct {valid, op, addr, delta}.
  - saturate function parameterised by the bounds.
- Sub-module `stdp_sat_add`: combinational widen, add and clamp, with a sat flag output. The pipeline and arbiter stay in the top module.

## Test plan
- Single update: weight[3]=100, delta=+5 → ram_we at t+2, addr 3, wdata 105; upd_count=1.
- Back-to-back: three updates to addr 7 (init 0) with deltas +1, +2, +3 on consecutive cycles → wdata 1, 3, 6.
- Gap forwarding: updates to addr 2 at t and t+2, with an addr-5 update at t+1; weight[2]=10, deltas +4 and +4 → second wdata 18.
- Saturation: weight=131070, delta=+5 → wdata 131071, sat_count=1. Weight=-131072, delta=-1 → -131072, sat_count=2.
- Arbitration: inf_req held high and upd_valid high → upd_ready pulses after exactly 4 denied cycles, with inf_ready=0 in that cycle. An inf read to an address updated 1 cycle earlier returns the updated value.
- Reset mid-update: assert rst at t+1 after an update is accepted → no ram_we; all outputs return to reset values.
